// File: rtl/wb_stage.sv
// MEM->WB pipeline latch and writeback stage: selects register-file write data,
// drives the WB forwarding tap, and owns the sticky core halt and retired count.
module wb_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              advance,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] porto,
    input  logic [WORD_W-1:0] dmemload,
    input  logic [WORD_W-1:0] npc,
    input  logic [REG_W-1:0]  wsel,
    input  logic              regen,
    input  logic [1:0]        regsrc,
    input  logic              halt,
    output logic              rf_wen,
    output logic [REG_W-1:0]  rf_wsel,
    output logic [WORD_W-1:0] rf_wdat,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_sel,
    output logic [WORD_W-1:0] fwd_dat,
    output logic              halt_out,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;

    logic              valid_l;
    logic              regen_l;
    logic              halt_l;
    logic [WORD_W-1:0] porto_l;
    logic [WORD_W-1:0] dmemload_l;
    logic [WORD_W-1:0] npc_l;
    logic [REG_W-1:0]  wsel_l;
    logic [1:0]        regsrc_l;
    logic              halt_q;
    logic [CNT_W-1:0]  retired_q;
    logic              capture;
    logic [WORD_W-1:0] wdat;

    // Transfer contract: the latch takes the MEM bundle only when advance=1 and
    // flush=0 while not halted; flush beats advance, and a halted core ignores both.
    assign capture = ~halt_q & ~flush & advance;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_l    <= 1'b0;
            regen_l    <= 1'b0;
            halt_l     <= 1'b0;
            porto_l    <= '0;
            dmemload_l <= '0;
            npc_l      <= '0;
            wsel_l     <= '0;
            regsrc_l   <= '0;
        end else if (!halt_q) begin
            if (flush) begin
                // Data fields are left as-is; only the control bits kill the slot.
                valid_l <= 1'b0;
                regen_l <= 1'b0;
                halt_l  <= 1'b0;
            end else if (advance) begin
                valid_l    <= in_valid;
                regen_l    <= regen;
                halt_l     <= halt;
                porto_l    <= porto;
                dmemload_l <= dmemload;
                npc_l      <= npc;
                wsel_l     <= wsel;
                regsrc_l   <= regsrc;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_q | (valid_l & halt_l);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            retired_q <= '0;
        end else if (capture && in_valid && (retired_q != CNT_MAX)) begin
            retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        wdat = porto_l;
        case (regsrc_l)
            SRC_ALU:  wdat = porto_l;
            SRC_LOAD: wdat = dmemload_l;
            SRC_LINK: wdat = npc_l;
            default:  wdat = porto_l;
        endcase
    end

    // A held latch re-presents the same write every cycle; the register file tolerates it.
    assign rf_wen    = valid_l & regen_l & (wsel_l != '0) & ~halt_l & ~halt_q;
    assign rf_wsel   = wsel_l;
    assign rf_wdat   = wdat;
    assign fwd_valid = rf_wen;
    assign fwd_sel   = wsel_l;
    assign fwd_dat   = wdat;
    assign halt_out  = halt_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed walk-through then randomized traffic, checked
// against an instruction-level model via a per-cycle expected queue.
module tb_wb_stage;

    logic        CLK;
    logic        nRST;
    logic        advance;
    logic        flush;
    logic        in_valid;
    logic [31:0] porto;
    logic [31:0] dmemload;
    logic [31:0] npc;
    logic [4:0]  wsel;
    logic        regen;
    logic [1:0]  regsrc;
    logic        halt;

    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        fwd_valid;
    logic [4:0]  fwd_sel;
    logic [31:0] fwd_dat;
    logic        halt_out;
    logic [31:0] retired;

    logic        rf_wen_s;
    logic [4:0]  rf_wsel_s;
    logic [31:0] rf_wdat_s;
    logic        fwd_valid_s;
    logic [4:0]  fwd_sel_s;
    logic [31:0] fwd_dat_s;
    logic        halt_out_s;
    logic [1:0]  retired_s;

    wb_stage #(.WORD_W(32), .REG_W(5), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush), .in_valid(in_valid),
        .porto(porto), .dmemload(dmemload), .npc(npc), .wsel(wsel), .regen(regen),
        .regsrc(regsrc), .halt(halt), .rf_wen(rf_wen), .rf_wsel(rf_wsel),
        .rf_wdat(rf_wdat), .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_dat(fwd_dat),
        .halt_out(halt_out), .retired(retired)
    );

    // Narrow-counter copy on the same stimulus so saturation is reached quickly.
    wb_stage #(.WORD_W(32), .REG_W(5), .CNT_W(2)) dut_s (
        .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush), .in_valid(in_valid),
        .porto(porto), .dmemload(dmemload), .npc(npc), .wsel(wsel), .regen(regen),
        .regsrc(regsrc), .halt(halt), .rf_wen(rf_wen_s), .rf_wsel(rf_wsel_s),
        .rf_wdat(rf_wdat_s), .fwd_valid(fwd_valid_s), .fwd_sel(fwd_sel_s),
        .fwd_dat(fwd_dat_s), .halt_out(halt_out_s), .retired(retired_s)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One slot holding the last accepted instruction, plus halt and counters.
    typedef struct {
        logic        valid;
        logic        regen;
        logic        halt;
        logic [31:0] porto;
        logic [31:0] dml;
        logic [31:0] npc;
        logic [4:0]  wsel;
        logic [1:0]  src;
    } slot_t;

    slot_t       m_slot;
    logic        m_halted;
    longint      m_ret;
    longint      m_ret_s;

    logic [72:0] exp_q[$];

    task automatic model_reset();
        m_slot.valid = 0; m_slot.regen = 0; m_slot.halt = 0;
        m_slot.porto = 0; m_slot.dml = 0; m_slot.npc = 0; m_slot.wsel = 0; m_slot.src = 0;
        m_halted = 0;
        m_ret    = 0;
        m_ret_s  = 0;
    endtask

    task automatic model_edge();
        logic was_halted;
        was_halted = m_halted;
        if (m_slot.valid && m_slot.halt) m_halted = 1;
        if (!was_halted) begin
            if (flush) begin
                m_slot.valid = 0; m_slot.regen = 0; m_slot.halt = 0;
            end else if (advance) begin
                m_slot.valid = in_valid; m_slot.regen = regen; m_slot.halt = halt;
                m_slot.porto = porto; m_slot.dml = dmemload; m_slot.npc = npc;
                m_slot.wsel = wsel; m_slot.src = regsrc;
                if (in_valid) begin
                    if (m_ret < 64'hFFFF_FFFF) m_ret++;
                    if (m_ret_s < 3) m_ret_s++;
                end
            end
        end
    endtask

    function automatic logic [72:0] model_outputs();
        logic        wen;
        logic [31:0] wd;
        logic [31:0] r;
        logic [1:0]  rs;
        wen = m_slot.valid && m_slot.regen && (m_slot.wsel != 0) && !m_slot.halt && !m_halted;
        if (m_slot.src == 2'd1)      wd = m_slot.dml;
        else if (m_slot.src == 2'd2) wd = m_slot.npc;
        else                         wd = m_slot.porto;
        r  = m_ret[31:0];
        rs = m_ret_s[1:0];
        return {wen, m_slot.wsel, wd, m_halted, r, rs};
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic adv, input logic fl, input logic iv,
                         input logic [31:0] p, input logic [31:0] d, input logic [31:0] n,
                         input logic [4:0] ws, input logic re, input logic [1:0] rs,
                         input logic h);
        advance = adv; flush = fl; in_valid = iv;
        porto = p; dmemload = d; npc = n; wsel = ws; regen = re; regsrc = rs; halt = h;
        @(posedge CLK);
        model_edge();
        exp_q.push_back(model_outputs());
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("rst_rf_wsel", {27'd0, rf_wsel}, 32'd0);
        check("rst_rf_wdat", rf_wdat, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_halt_out", {31'd0, halt_out}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_retired_s", {30'd0, retired_s}, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [72:0] e;
            logic        e_wen;
            logic [4:0]  e_wsel;
            logic [31:0] e_wdat;
            e      = exp_q.pop_front();
            e_wen  = e[72];
            e_wsel = e[71:67];
            e_wdat = e[66:35];
            check("rf_wen", {31'd0, rf_wen}, {31'd0, e_wen});
            check("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_wen});
            check("halt_out", {31'd0, halt_out}, {31'd0, e[34]});
            check("retired", retired, e[33:2]);
            check("retired_sat", {30'd0, retired_s}, {30'd0, e[1:0]});
            check("s_rf_wen", {31'd0, rf_wen_s}, {31'd0, e_wen});
            check("s_fwd_valid", {31'd0, fwd_valid_s}, {31'd0, e_wen});
            check("s_halt_out", {31'd0, halt_out_s}, {31'd0, e[34]});
            if (e_wen) begin
                check("rf_wsel", {27'd0, rf_wsel}, {27'd0, e_wsel});
                check("rf_wdat", rf_wdat, e_wdat);
                check("fwd_sel", {27'd0, fwd_sel}, {27'd0, e_wsel});
                check("fwd_dat", fwd_dat, e_wdat);
                check("s_rf_wsel", {27'd0, rf_wsel_s}, {27'd0, e_wsel});
                check("s_rf_wdat", rf_wdat_s, e_wdat);
                check("s_fwd_sel", {27'd0, fwd_sel_s}, {27'd0, e_wsel});
                check("s_fwd_dat", fwd_dat_s, e_wdat);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        nRST = 1'b0;
        advance = 0; flush = 0; in_valid = 0; porto = 0; dmemload = 0; npc = 0;
        wsel = 0; regen = 0; regsrc = 0; halt = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("init_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("init_halt_out", {31'd0, halt_out}, 32'd0);
        check("init_retired", retired, 32'd0);
        nRST = 1'b1;

        // ALU write and mux coverage
        apply(1, 0, 1, 32'h0000_00A5, 32'h0, 32'h0, 5'd5, 1, 2'b00, 0);
        check("alu_wen", {31'd0, rf_wen}, 32'd1);
        check("alu_wsel", {27'd0, rf_wsel}, 32'd5);
        check("alu_wdat", rf_wdat, 32'h0000_00A5);
        check("alu_fwd_dat", fwd_dat, 32'h0000_00A5);
        check("alu_retired", retired, 32'd1);
        apply(1, 0, 1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 5'd6, 1, 2'b01, 0);
        check("load_wdat", rf_wdat, 32'hDEAD_BEEF);
        apply(1, 0, 1, 32'h2222_2222, 32'h0, 32'h0000_0104, 5'd7, 1, 2'b10, 0);
        check("link_wdat", rf_wdat, 32'h0000_0104);
        apply(1, 0, 1, 32'h1234_5678, 32'h3333_3333, 32'h4444_4444, 5'd8, 1, 2'b11, 0);
        check("rsvd_wdat", rf_wdat, 32'h1234_5678);

        // $0 write and flush-beats-advance
        apply(1, 0, 1, 32'h9, 32'h0, 32'h0, 5'd0, 1, 2'b00, 0);
        check("r0_wen", {31'd0, rf_wen}, 32'd0);
        check("r0_retired", retired, 32'd5);
        apply(1, 1, 1, 32'hA, 32'h0, 32'h0, 5'd3, 1, 2'b00, 0);
        check("flush_wen", {31'd0, rf_wen}, 32'd0);
        check("flush_retired", retired, 32'd5);

        // Stall hold
        apply(1, 0, 1, 32'h55, 32'h0, 32'h0, 5'd7, 1, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 1,
                  2'($urandom_range(0, 3)), 0);
            check("stall_wsel", {27'd0, rf_wsel}, 32'd7);
            check("stall_wdat", rf_wdat, 32'h55);
            check("stall_retired", retired, 32'd6);
        end

        // Halt
        apply(1, 0, 1, 32'h0, 32'h0, 32'h0, 5'd0, 0, 2'b00, 1);
        check("halt_pre", {31'd0, halt_out}, 32'd0);
        check("halt_ret", retired, 32'd7);
        apply(1, 0, 1, 32'h77, 32'h0, 32'h0, 5'd9, 1, 2'b00, 0);
        check("halt_set", {31'd0, halt_out}, 32'd1);
        check("halt_wen", {31'd0, rf_wen}, 32'd0);
        apply(1, 0, 1, 32'h78, 32'h0, 32'h0, 5'd10, 1, 2'b00, 0);
        check("halt_frozen", retired, 32'd8);
        check("halt_wen2", {31'd0, rf_wen}, 32'd0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (m_halted && ($urandom_range(0, 4) == 0)) begin
                do_reset();
            end else begin
                apply($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 7) != 0, $urandom, $urandom, $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 79) == 0);
            end
        end

        @(negedge CLK);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Consumer end of the MEM→WB pipeline boundary.
- Latches the MEM-stage bundle: ALU result, load data, link PC, destination register, register enable, register-source select, halt, valid.
- Under hazard-unit control (advance/flush), selects the writeback data and drives the register-file write port and a WB-stage forwarding tap.
- Owns the sticky halt for the core and a retired-instruction counter.

Parameters:
- WORD_W, 32, datapath word width.
- REG_W, 5, register select width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK  input  1  core clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- advance  input  1  hazard unit permits MEM→WB transfer this cycle (memory not stalled).
- flush  input  1  insert bubble into WB latch.
- in_valid  input  1  MEM stage holds a real instruction.
- porto  input  WORD_W  ALU result from MEM.
- dmemload  input  WORD_W  data-memory load word from MEM.
- npc  input  WORD_W  PC+4 of the instruction (link value).
- wsel  input  REG_W  destination register.
- regen  input  1  instruction writes a register.
- regsrc  input  2  writeback source select.
- halt  input  1  instruction is HALT.
- rf_wen  output  1  register-file write enable.
- rf_wsel  output  REG_W  register-file write address.
- rf_wdat  output  WORD_W  register-file write data.
- fwd_valid  output  1  WB forwarding tap valid (equals rf_wen).
- fwd_sel  output  REG_W  forwarded register (equals rf_wsel).
- fwd_dat  output  WORD_W  forwarded data (equals rf_wdat).
- halt_out  output  1  sticky core halt.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - Clock is CLK; reset is nRST, asynchronous, active-low.
  - While nRST=0, all latch fields, halt_out and retired are 0.
  - Hence rf_wen=0, rf_wsel=0, rf_wdat=0, fwd_valid=0.
- Latch update on CLK rising edge, priority order:
  1. halted: if halt_out=1, the latch holds and all inputs are ignored, including flush.
  2. flush=1: latch valid=0, regen=0, halt=0; data fields are don't-care and are held.
  3. advance=1: capture all inputs.
  4. Otherwise: hold.
- Latency: a value captured at edge N drives rf_*/fwd_* combinationally from the latch during cycle N+1. Writeback data is not registered a second time.
- Writeback mux on latched regsrc:
  - 00: porto_l
  - 01: dmemload_l
  - 10: npc_l (JAL link)
  - 11: reserved, selects porto_l
- rf_wen = valid_l & regen_l & (wsel_l != 0) & ~halt_l.
  - Writes to $0 are never issued.
  - A flushed bubble never writes.
- rf_wsel = wsel_l and rf_wdat = mux output, always driven; don't-care when rf_wen=0.
- Write repetition during hold: if advance=0 for several cycles, the same write is presented repeatedly.
  - This is legal: the register file write is idempotent.
  - retired does not double-count (see counter rule).
- Halt:
  - halt_out sets on the edge after which valid_l=1 and halt_l=1 are latched. Concretely, halt_out is registered from (valid_l & halt_l) on the following edge.
  - It then stays 1 until reset.
  - Once halt_out=1, rf_wen is forced to 0.
- Retired counter: increments by 1 on an edge where capture occurs with in_valid=1 and halt_out=0.
  - A HALT instruction counts.
  - Saturates at all-ones; no wrap.
- Simultaneous flush & advance: flush wins and the incoming instruction is dropped (not counted).
- Reset mid-stall or mid-halt: returns to the reset state immediately, asynchronously.

Test Plan:
- Reset & ALU write: release nRST; advance=1, in_valid=1, regen=1, wsel=5, regsrc=00, porto=0x0000_00A5 → next cycle rf_wen=1, rf_wsel=5, rf_wdat=0x0000_00A5, fwd_* identical, retired=1.
- Mux coverage: regsrc=01 with dmemload=0xDEAD_BEEF, then regsrc=10 with npc=0x0000_0104, then regsrc=11 with porto=0x1234_5678 → rf_wdat is 0xDEAD_BEEF, then 0x0000_0104, then 0x1234_5678 on successive cycles.
- $0 and bubbles:
  - wsel=0, regen=1, valid → rf_wen=0, retired increments.
  - flush=1 together with advance=1 → rf_wen=0, retired unchanged.
- Stall hold: capture a write to reg 7 = 0x55, then advance=0 for 3 cycles with changing inputs → rf_wsel=7, rf_wdat=0x55 held for 3 cycles, retired increments by 1 only.
- Halt:
  - Capture valid halt=1 → halt_out=1 one cycle later.
  - Further advance with valid regen=1 writes → rf_wen=0 and retired frozen.
  - Pulse nRST low mid-cycle → halt_out=0 and retired=0 immediately.
- Saturation: force retired to 0xFFFF_FFFE via back-door preload, then retire 3 instructions → retired ends at 0xFFFF_FFFF.
